// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Brief    : Multi-port register file for the dual-issue core. It has two
//            write ports, RD_PORTS combinational read ports, a pending-write
//            scoreboard with one bit per register, and a sequential clear
//            engine. Register 0 always reads as zero.
// Options  : REGFILE_BYPASS_EN - forwards write-port data to matching reads
//            in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int RD_PORTS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   we,
  input  logic [2*ADDR_W-1:0]          waddr,
  input  logic [2*DATA_W-1:0]          wdata,
  input  logic [RD_PORTS-1:0]          re,
  input  logic [RD_PORTS*ADDR_W-1:0]   raddr,
  output logic [RD_PORTS*DATA_W-1:0]   rdata,
  output logic [RD_PORTS-1:0]          rpend,
  input  logic                         sb_set,
  input  logic [ADDR_W-1:0]            sb_addr,
  input  logic                         clr_req,
  output logic                         busy
);

  localparam int DEPTH = 2**ADDR_W;

  localparam logic [0:0]        c_IDLE     = 1'b0;
  localparam logic [0:0]        c_CLEAR    = 1'b1;
  localparam logic [ADDR_W-1:0] c_LAST_IDX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] c_ZERO     = '0;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_pend;
  logic              w_clearing;
  logic              w_start;

  assign w_clearing = (r_state == c_CLEAR);
  assign w_start    = (r_state == c_IDLE) && clr_req;

  // Clear-engine state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Clear-engine next state: leave CLEAR once the last index has been zeroed
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (clr_req) w_state_nxt = c_CLEAR;
      c_CLEAR: if (r_idx == c_LAST_IDX) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Clear-engine outputs
  always_comb begin
    busy = w_clearing;
  end

  // Clear index: restarts at 0 on each clear and saturates on the last entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      r_idx <= '0;
    else if (w_start)                             r_idx <= '0;
    else if (w_clearing && r_idx != c_LAST_IDX)   r_idx <= r_idx + 1'b1;
  end

  // Storage: the clear engine owns the array while busy; port 1 is applied last so it wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < DEPTH; d++) r_regs[d] <= '0;
    end else if (w_clearing) begin
      r_regs[r_idx] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (we[k] && waddr[k*ADDR_W +: ADDR_W] != c_ZERO)
          r_regs[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // Scoreboard: write-back clears and issue sets; the set comes last so the newer producer wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
    end else if (w_start) begin
      r_pend <= '0;
    end else if (!w_clearing) begin
      for (int k = 0; k < 2; k++) begin
        if (we[k]) r_pend[waddr[k*ADDR_W +: ADDR_W]] <= 1'b0;
      end
      if (sb_set && sb_addr != c_ZERO) r_pend[sb_addr] <= 1'b1;
    end
  end

  generate
    for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic [DATA_W-1:0] w_rd;

      assign w_ra = raddr[i*ADDR_W +: ADDR_W];

      // Read mux: zero when disabled, in reset, addressing r0 or during a clear
      always_comb begin
        w_rd = '0;
        if (!rst && re[i] && w_ra != c_ZERO && !w_clearing) begin
          w_rd = r_regs[w_ra];
`ifdef REGFILE_BYPASS_EN
          for (int k = 0; k < 2; k++) begin
            if (we[k] && waddr[k*ADDR_W +: ADDR_W] == w_ra)
              w_rd = wdata[k*DATA_W +: DATA_W];
          end
`endif
        end
      end

      assign rdata[i*DATA_W +: DATA_W] = w_rd;
      assign rpend[i] = !w_clearing && (w_ra != c_ZERO) && r_pend[w_ra];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Brief    : Directed self-checking bench for regfile_mp.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int RD_PORTS = 4;
  localparam int DEPTH    = 32;

  logic                        clk;
  logic                        rst;
  logic [1:0]                  we;
  logic [2*ADDR_W-1:0]         waddr;
  logic [2*DATA_W-1:0]         wdata;
  logic [RD_PORTS-1:0]         re;
  logic [RD_PORTS*ADDR_W-1:0]  raddr;
  logic [RD_PORTS*DATA_W-1:0]  rdata;
  logic [RD_PORTS-1:0]         rpend;
  logic                        sb_set;
  logic [ADDR_W-1:0]           sb_addr;
  logic                        clr_req;
  logic                        busy;

  int checks;
  int errors;

  regfile_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_PORTS(RD_PORTS)
  ) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata), .rpend(rpend),
    .sb_set(sb_set), .sb_addr(sb_addr), .clr_req(clr_req), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where inputs are changed
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reads(input logic [ADDR_W-1:0] a);
    re = '1;
    for (int i = 0; i < RD_PORTS; i++) raddr[i*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic idle_inputs();
    we = '0; waddr = '0; wdata = '0; sb_set = 1'b0; sb_addr = '0; clr_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    set_reads(5'd5);
    tick(); tick();
    #2;
    for (int i = 0; i < RD_PORTS; i++) begin
      checks++;
      if (rdata[i*DATA_W +: DATA_W] !== 32'h0) begin
        errors++; $display("FAIL reset_in_rst_rdata[%0d] got %h exp 0", i, rdata[i*DATA_W +: DATA_W]);
      end
    end
    rst = 1'b0;
    tick();
    #2;
    for (int i = 0; i < RD_PORTS; i++) begin
      checks++;
      if (rdata[i*DATA_W +: DATA_W] !== 32'h0) begin
        errors++; $display("FAIL reset_rdata[%0d] got %h exp 0", i, rdata[i*DATA_W +: DATA_W]);
      end
    end
    checks++;
    if (rpend !== 4'b0000) begin errors++; $display("FAIL reset_rpend got %b exp 0000", rpend); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_dual_write();
    // Both ports to addr 3: port 1 must win
    we = 2'b11; waddr = {5'd3, 5'd3}; wdata = {32'h22222222, 32'h11111111};
    tick();
    idle_inputs();
    set_reads(5'd3);
    #2;
    for (int i = 0; i < RD_PORTS; i++) begin
      checks++;
      if (rdata[i*DATA_W +: DATA_W] !== 32'h22222222) begin
        errors++; $display("FAIL dual_same_addr[%0d] got %h exp 22222222", i, rdata[i*DATA_W +: DATA_W]);
      end
    end
    // Write to r0 is dropped
    we = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'h0, 32'hFFFFFFFF};
    tick();
    idle_inputs();
    set_reads(5'd0);
    #2;
    checks++;
    if (rdata[31:0] !== 32'h0) begin errors++; $display("FAIL r0_write got %h exp 0", rdata[31:0]); end
    // Two independent addresses in one cycle
    we = 2'b11; waddr = {5'd6, 5'd4}; wdata = {32'h00000066, 32'h00000044};
    tick();
    idle_inputs();
    raddr = {5'd0, 5'd3, 5'd6, 5'd4};
    re = 4'b1111;
    #2;
    checks++;
    if (rdata !== {32'h0, 32'h22222222, 32'h00000066, 32'h00000044}) begin
      errors++; $display("FAIL dual_distinct got %h exp %h", rdata, {32'h0, 32'h22222222, 32'h00000066, 32'h00000044});
    end
    // Disabled read port returns zero
    re = 4'b1101;
    #1;
    checks++;
    if (rdata[63:32] !== 32'h0) begin errors++; $display("FAIL re_disabled got %h exp 0", rdata[63:32]); end
  endtask

  task automatic test_bypass();
    logic [DATA_W-1:0] exp_same;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'hDEADBEEF;
`else
    exp_same = 32'h0;
`endif
    we = 2'b01; waddr = {5'd0, 5'd7}; wdata = {32'h0, 32'hDEADBEEF};
    set_reads(5'd7);
    #2;
    checks++;
    if (rdata[31:0] !== exp_same) begin errors++; $display("FAIL same_cycle_read got %h exp %h", rdata[31:0], exp_same); end
    tick();
    idle_inputs();
    #2;
    checks++;
    if (rdata[127:96] !== 32'hDEADBEEF) begin errors++; $display("FAIL after_write_read got %h exp deadbeef", rdata[127:96]); end
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    raddr = {5'd0, 5'd0, 5'd10, 5'd9};
    re = 4'b1111;
    sb_set = 1'b1; sb_addr = 5'd9;
    #2;
    checks++;
    if (rpend[0] !== 1'b0) begin errors++; $display("FAIL sb_before_edge got %b exp 0", rpend[0]); end
    tick();
    sb_set = 1'b0;
    #2;
    checks++;
    if (rpend !== 4'b0001) begin errors++; $display("FAIL sb_set got %b exp 0001", rpend); end
    // Set and clear together: set wins
    sb_set = 1'b1; sb_addr = 5'd9;
    we = 2'b10; waddr = {5'd9, 5'd0}; wdata = {32'h99, 32'h0};
    tick();
    idle_inputs();
    #2;
    checks++;
    if (rpend[0] !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %b exp 1", rpend[0]); end
    // Write alone clears
    we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h999};
    tick();
    idle_inputs();
    #2;
    checks++;
    if (rpend[0] !== 1'b0) begin errors++; $display("FAIL sb_write_clears got %b exp 0", rpend[0]); end
    // r0 can never be pending
    sb_set = 1'b1; sb_addr = 5'd0;
    tick();
    sb_set = 1'b0;
    raddr = '0;
    #2;
    checks++;
    if (rpend !== 4'b0000) begin errors++; $display("FAIL sb_r0 got %b exp 0000", rpend); end
  endtask

  task automatic fill_index();
    for (int a = 1; a < DEPTH; a += 2) begin
      we = 2'b01;
      waddr[4:0] = 5'(a);
      wdata[31:0] = 32'(a);
      if (a + 1 < DEPTH) begin
        we[1] = 1'b1;
        waddr[9:5] = 5'(a + 1);
        wdata[63:32] = 32'(a + 1);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    int n;
    fill_index();
    sb_set = 1'b1; sb_addr = 5'd12;
    tick();
    idle_inputs();
    raddr = {5'd20, 5'd31, 5'd17, 5'd12};
    re = 4'b1111;
    #2;
    checks++;
    if (rdata !== {32'd20, 32'd31, 32'd17, 32'd12}) begin
      errors++; $display("FAIL fill_readback got %h exp %h", rdata, {32'd20, 32'd31, 32'd17, 32'd12});
    end
    checks++;
    if (rpend !== 4'b0001) begin errors++; $display("FAIL pend_before_clear got %b exp 0001", rpend); end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (n == 20) begin
        we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h33};
        sb_set = 1'b1; sb_addr = 5'd20;
      end else begin
        idle_inputs();
      end
      set_reads(5'd31);
      #2;
      if (rdata[31:0] !== 32'h0) begin
        checks++; errors++; $display("FAIL read_during_clear cycle %0d got %h exp 0", n, rdata[31:0]);
      end
      tick();
    end
    idle_inputs();
    checks++;
    if (n != 32) begin errors++; $display("FAIL clear_busy_cycles got %0d exp 32", n); end
    for (int a = 1; a < DEPTH; a++) begin
      set_reads(5'(a));
      #1;
      checks++;
      if (rdata[(a%4)*DATA_W +: DATA_W] !== 32'h0 || rpend !== 4'b0000) begin
        errors++; $display("FAIL after_clear addr %0d got %h/%b exp 0/0000", a, rdata[(a%4)*DATA_W +: DATA_W], rpend);
      end
    end
    we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'h0000ABCD};
    tick();
    idle_inputs();
    set_reads(5'd5);
    #2;
    checks++;
    if (rdata[31:0] !== 32'h0000ABCD) begin errors++; $display("FAIL write_after_clear got %h exp 0000abcd", rdata[31:0]); end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    we = 2'b11; waddr = {5'd31, 5'd2}; wdata = {32'h1F, 32'h2};
    tick();
    idle_inputs();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_clear_busy got %b exp 0", busy); end
    #1;
    rst = 1'b0;
    set_reads(5'd31);
    #1;
    checks++;
    if (rdata[31:0] !== 32'h0) begin errors++; $display("FAIL rst_mid_clear_r31 got %h exp 0", rdata[31:0]); end
    tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (n != 32) begin errors++; $display("FAIL restart_clear_cycles got %0d exp 32", n); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    re = '0;
    raddr = '0;
    idle_inputs();
    test_reset();
    test_dual_write();
    test_bypass();
    test_scoreboard();
    test_clear();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
